// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC and the IF/ID register, talks to
// instruction memory over a level req / pulse ack handshake.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_code_IfId,
  output logic [31:0] pc_plus4_IfId,
  output logic        valid_IfId
);

  typedef enum logic [1:0] {START, FETCH, BUFFER, SQUASH} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pc_inc;
  logic [31:0] sq_addr, sq_addr_n;
  logic [31:0] skid, skid_n;
  ifid_t       ifid, ifid_n;

  assign pc_inc = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= START;
      pc      <= RESET_PC;
      sq_addr <= '0;
      skid    <= '0;
      ifid    <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      sq_addr <= sq_addr_n;
      skid    <= skid_n;
      ifid    <= ifid_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    sq_addr_n = sq_addr;
    skid_n    = skid;
    ifid_n    = ifid;
    if (redirect_valid) begin
      // Redirect beats stall; a bubble keeps the old pc_plus4.
      pc_n         = redirect_pc;
      ifid_n.instr = '0;
      ifid_n.valid = 1'b0;
      skid_n       = '0;
      if (imem_req && !imem_ack) begin
        // Request still outstanding: keep driving it until memory answers.
        state_n = SQUASH;
        if (state == FETCH) sq_addr_n = pc;
      end else begin
        state_n = FETCH;
      end
    end else begin
      case (state)
        START: state_n = FETCH;
        FETCH: begin
          if (imem_ack) begin
            pc_n = pc_inc;
            if (stall) begin
              skid_n  = imem_rdata;
              state_n = BUFFER;
            end else begin
              ifid_n.instr = imem_rdata;
              ifid_n.pc4   = pc_inc;
              ifid_n.valid = 1'b1;
            end
          end else if (!stall) begin
            ifid_n.instr = '0;
            ifid_n.valid = 1'b0;
          end
        end
        BUFFER: begin
          // pc already points past the buffered word, so it is its pc+4.
          if (!stall) begin
            ifid_n.instr = skid;
            ifid_n.pc4   = pc;
            ifid_n.valid = 1'b1;
            state_n      = FETCH;
          end
        end
        SQUASH: if (imem_ack) state_n = FETCH;
        default: state_n = START;
      endcase
    end
  end

  assign imem_req              = (state == FETCH) || (state == SQUASH);
  assign imem_addr             = (state == SQUASH) ? sq_addr : pc;
  assign Instruction_code_IfId = ifid.instr;
  assign pc_plus4_IfId         = ifid.pc4;
  assign valid_IfId            = ifid.valid;

endmodule
